// File: rtl/ripple_adder_4bit.sv
// Registered ripple-carry adder: a chain of single-bit full-adder cells
// feeding a one-stage output register that also carries the status flags.

// Single-bit full adder used as one link of the ripple chain.
module ripple_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    // Propagate term is shared between the sum bit and the carry-out.
    always_comb begin
        half_sum = a ^ b;
        s        = half_sum ^ cin;
        cout     = (a & b) | (cin & half_sum);
    end

endmodule

// Top level: WIDTH cells chained LSB to MSB, results captured on in_valid.
module ripple_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero,
    output logic             out_valid
);

    // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB cell.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;
    logic             ovf_next;
    logic             zero_next;

    assign carry[0] = Cin;

    // One full-adder cell per bit; the carry ripples serially, no lookahead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ripple_full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    // Signed overflow shows up as disagreement between carry into and out of the MSB.
    always_comb begin
        ovf_next  = carry[WIDTH] ^ carry[WIDTH-1];
        zero_next = ~|sum_bits;
    end

    // Output register: reset clears everything (Zero included), a valid operand
    // loads fresh results, otherwise results hold and out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum       <= '0;
            Cout      <= 1'b0;
            Ovf       <= 1'b0;
            Zero      <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            Sum       <= sum_bits;
            Cout      <= carry[WIDTH];
            Ovf       <= ovf_next;
            Zero      <= zero_next;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ripple_adder_4bit.sv
// Self-checking bench for ripple_adder_4bit: directed steps plus an exhaustive
// sweep, with a scoreboard queue holding results expected one cycle later.
module tb_ripple_adder_4bit;

    typedef struct {
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       in_valid;
    logic [3:0] Sum;
    logic       Cout;
    logic       Ovf;
    logic       Zero;
    logic       out_valid;

    exp_t       sb[$];
    exp_t       model;
    logic       model_valid;
    logic       pend_rst;
    logic       pend_valid;
    int         checks;
    int         errors;

    ripple_adder_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .Zero      (Zero),
        .out_valid (out_valid)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result computed from plain integer arithmetic.
    function automatic exp_t refModel(input logic [3:0] a, input logic [3:0] b, input logic c);
        exp_t e;
        int   total;
        int   sa;
        int   sb_i;
        int   ssum;
        total  = int'(a) + int'(b) + int'(c);
        sa     = a[3] ? int'(a) - 16 : int'(a);
        sb_i   = b[3] ? int'(b) - 16 : int'(b);
        ssum   = sa + sb_i + int'(c);
        e.sum  = 4'(total);
        e.cout = (total > 15);
        e.ovf  = (ssum > 7) || (ssum < -8);
        e.zero = ((total % 16) == 0);
        return e;
    endfunction

    // Drive one cycle of inputs; a capture that is not masked by reset queues its result.
    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] a,
                                 input logic [3:0] b, input logic c);
        rst        = r;
        in_valid   = v;
        A          = a;
        B          = b;
        Cin        = c;
        pend_rst   = r;
        pend_valid = v;
        if (!r && v) sb.push_back(refModel(a, b, c));
    endtask

    // After the edge, advance the model and compare every output against it.
    task automatic checkOutput(input string tag);
        if (pend_rst) begin
            model       = '{sum: 4'h0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
            model_valid = 1'b0;
        end else if (pend_valid) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("[TB] FAIL %s scoreboard observed empty expected entry", tag);
            end
            if (sb.size() > 0) model = sb.pop_front();
            model_valid = 1'b1;
        end else begin
            model_valid = 1'b0;
        end
        checks++;
        assert (Sum === model.sum) else begin
            errors++;
            $error("[TB] FAIL %s Sum observed %b expected %b", tag, Sum, model.sum);
        end
        checks++;
        assert (Cout === model.cout) else begin
            errors++;
            $error("[TB] FAIL %s Cout observed %b expected %b", tag, Cout, model.cout);
        end
        checks++;
        assert (Ovf === model.ovf) else begin
            errors++;
            $error("[TB] FAIL %s Ovf observed %b expected %b", tag, Ovf, model.ovf);
        end
        checks++;
        assert (Zero === model.zero) else begin
            errors++;
            $error("[TB] FAIL %s Zero observed %b expected %b", tag, Zero, model.zero);
        end
        checks++;
        assert (out_valid === model_valid) else begin
            errors++;
            $error("[TB] FAIL %s out_valid observed %b expected %b", tag, out_valid, model_valid);
        end
    endtask

    // One full clock step: drive, clock, sample 1 unit after the edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [3:0] a, input logic [3:0] b, input logic c);
        applyStimulus(r, v, a, b, c);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Directed constant check for values called out explicitly.
    task automatic checkConst(input string tag, input logic [3:0] s, input logic co,
                              input logic ov, input logic z);
        checks++;
        assert (Sum === s && Cout === co && Ovf === ov && Zero === z) else begin
            errors++;
            $error("[TB] FAIL %s observed S=%b C=%b O=%b Z=%b expected S=%b C=%b O=%b Z=%b",
                   tag, Sum, Cout, Ovf, Zero, s, co, ov, z);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model       = '{sum: 4'h0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        model_valid = 1'b0;

        // Reset held two cycles with a valid all-ones operation pending.
        step("reset0", 1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
        checkConst("reset0_const", 4'h0, 1'b0, 1'b0, 1'b0);
        step("reset1", 1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
        checkConst("reset1_const", 4'h0, 1'b0, 1'b0, 1'b0);
        step("post_reset", 1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
        checkConst("post_reset_const", 4'hF, 1'b1, 1'b0, 1'b0);

        // Directed back-to-back operations.
        step("dir_1", 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0);
        checkConst("dir_1_const", 4'b0001, 1'b0, 1'b0, 1'b0);
        step("dir_2", 1'b0, 1'b1, 4'b1010, 4'b0011, 1'b0);
        checkConst("dir_2_const", 4'b1101, 1'b0, 1'b0, 1'b0);
        step("dir_3", 1'b0, 1'b1, 4'b1101, 4'b1010, 1'b1);
        checkConst("dir_3_const", 4'b1000, 1'b1, 1'b0, 1'b0);

        // Signed overflow and wrap.
        step("ovf_pos", 1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
        checkConst("ovf_pos_const", 4'b1000, 1'b0, 1'b1, 1'b0);
        step("ovf_neg", 1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0);
        checkConst("ovf_neg_const", 4'b0000, 1'b1, 1'b1, 1'b1);

        // Carry ripples through the full chain.
        step("ripple", 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1);
        checkConst("ripple_const", 4'b0000, 1'b1, 1'b0, 1'b1);

        // Hold: one valid op then three idle cycles with changing operands.
        step("hold_load", 1'b0, 1'b1, 4'b0110, 4'b0101, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("hold_idle", 1'b0, 1'b0, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            checkConst("hold_const", 4'b1011, 1'b0, 1'b1, 1'b0);
        end

        // Reset in the middle of a stream discards the operation on that edge.
        step("mid_a", 1'b0, 1'b1, 4'b0011, 4'b0100, 1'b0);
        step("mid_rst", 1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
        step("mid_b", 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1);

        // Exhaustive sweep of all operand and carry combinations, back to back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    step("exh", 1'b0, 1'b1, 4'(a), 4'(b), 1'(c));
                end
            end
        end

        step("drain", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("[TB] FAIL drain scoreboard observed %0d entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
